// File: rtl/fp_mult_arbiter_pkg.sv
// Shared definitions for the FP unit arbiters: FP32 constants, default width and the in-flight tag type.
package fp_mult_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  // Tag index is sized for the largest supported requester count (8)
  localparam int TAG_IDX_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/fp_mult_arbiter_rr_arbiter.sv
// Round-robin grant over N_REQ requesters with its own rotating priority pointer.
// Reusable for any shared single-issue unit.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;

  // Scan upward from rr_ptr with wrap; the first valid requester wins
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_valid && en && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined FP32 multiplier among N_REQ lanes: round-robin issue,
// owner tags travel alongside the product and steer each result back.
module fp_mult_arbiter
  import fp_mult_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MULT_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
  output logic                        mul_valid_in,
  output logic [DATA_WIDTH-1:0]       mul_a,
  output logic [DATA_WIDTH-1:0]       mul_b,
  input  logic                        mul_valid_out,
  input  logic [DATA_WIDTH-1:0]       mul_out,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        busy,
  output logic                        err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MULT_LAT + 1);

  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic [DATA_WIDTH-1:0] a_arr [N_REQ];
  logic [DATA_WIDTH-1:0] b_arr [N_REQ];
  tag_t                  tag_q [MULT_LAT];
  tag_t                  last_tag;
  logic [CNT_W-1:0]      count;

  // No grants while reset is held, so nothing issued then can be lost silently
  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .en          (en & ~reset),
    .req_valid   (req_valid),
    .grant       (req_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign mul_valid_in = grant_valid;

  always_comb begin
    mul_a = DATA_WIDTH'(FP_ZERO);
    mul_b = DATA_WIDTH'(FP_ZERO);
    if (grant_valid) begin
      mul_a = a_arr[grant_idx];
      mul_b = b_arr[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MULT_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: grant_valid, idx: TAG_IDX_W'(grant_idx)};
      for (int i = 1; i < MULT_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign last_tag = tag_q[MULT_LAT-1];

  // A result is delivered only when the tag and the multiplier agree it exists
  always_comb begin
    rsp_data  = mul_out;
    rsp_valid = '0;
    if (!reset && last_tag.valid && mul_valid_out) rsp_valid = N_REQ'(1) << last_tag.idx;
  end

  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if (last_tag.valid != mul_valid_out) err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({grant_valid, last_tag.valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign busy = (count != '0);

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Self-checking bench for fp_mult_arbiter with a 1-cycle FP multiplier model and
// a transaction-level reference (grant order, expected product per requester).
module tb_fp_mult_arbiter;
  import fp_mult_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk;
  logic            reset;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic            mul_valid_in;
  logic [DW-1:0]   mul_a;
  logic [DW-1:0]   mul_b;
  logic            mul_valid_out;
  logic [DW-1:0]   mul_out;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            busy;
  logic            err;

  logic            mv;
  logic [DW-1:0]   mo;
  logic            force_mv;

  int total = 0;
  int bad   = 0;

  // Reference state: operands as integers, rotating priority, one pending product
  int            ia [N];
  int            ib [N];
  int            ptr;
  logic          pend_valid;
  int            pend_idx;
  logic [31:0]   pend_data;
  logic          err_exp;
  int            last_grant;

  fp_mult_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MULT_LAT(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .mul_valid_in  (mul_valid_in),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_valid_out (mul_valid_out),
    .mul_out       (mul_out),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r2f(real r);
    logic [63:0] b;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
  endfunction

  function automatic real f2r(logic [31:0] f);
    if (f[30:0] == 31'h0) return 0.0;
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
  endfunction

  // Stand-in for FP_Top_Mult: one register stage, reset in step with the arbiter
  always @(posedge clk) begin
    if (reset) begin
      mv <= 1'b0;
      mo <= '0;
    end else begin
      mv <= mul_valid_in;
      mo <= r2f(f2r(mul_a) * f2r(mul_b));
    end
  end

  assign mul_valid_out = mv | force_mv;
  assign mul_out       = mo;

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(int i, int a, int b);
    ia[i] = a;
    ib[i] = b;
    req_a[i*DW +: DW] = (a == 1) ? FP_ONE : r2f(real'(a));
    req_b[i*DW +: DW] = r2f(real'(b));
  endtask

  // Check one cycle against the reference at the falling edge, then advance
  task automatic apply_stimulus();
    int g;
    int c;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      c = (ptr + k) % N;
      if (g < 0 && en && req_valid[c]) g = c;
    end
    exp_ready = (g >= 0) ? N'(1) << g : '0;
    check_output("req_ready", 32'(req_ready), 32'(exp_ready));
    check_output("mul_valid_in", 32'(mul_valid_in), 32'(g >= 0));
    check_output("mul_a", mul_a, (g >= 0) ? r2f(real'(ia[g])) : 32'h0);
    check_output("mul_b", mul_b, (g >= 0) ? r2f(real'(ib[g])) : 32'h0);
    check_output("rsp_valid", 32'(rsp_valid), pend_valid ? 32'(1) << pend_idx : 32'h0);
    if (pend_valid) check_output("rsp_data", rsp_data, pend_data);
    check_output("busy", 32'(busy), 32'(pend_valid));
    check_output("err", 32'(err), 32'(err_exp));
    if (force_mv && !pend_valid) err_exp = 1'b1;
    pend_valid = (g >= 0);
    pend_idx   = g;
    if (g >= 0) begin
      pend_data = r2f(real'(ia[g] * ib[g]));
      ptr = (g + 1) % N;
    end
    last_grant = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    ptr        = 0;
    pend_valid = 1'b0;
    err_exp    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    force_mv = 1'b0;
    for (int i = 0; i < N; i++) set_ops(i, 1, 1);
    ptr = 0;
    pend_valid = 1'b0;
    pend_idx = 0;
    pend_data = '0;
    err_exp = 1'b0;
    last_grant = -1;
    $display("[TB] start");

    do_reset();
    apply_stimulus();

    // Single requester: 2.0 * 3.0
    set_ops(0, 2, 3);
    req_valid = 4'b0001;
    apply_stimulus();
    req_valid = '0;
    #3;
    check_output("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check_output("single_rsp_data", rsp_data, 32'h40C0_0000);
    check_output("single_busy", 32'(busy), 32'h1);
    apply_stimulus();
    apply_stimulus();

    // All four held valid from reset: strict rotation
    do_reset();
    set_ops(0, 2, 5);
    set_ops(1, 3, 6);
    set_ops(2, 1, 7);
    set_ops(3, 5, 8);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      apply_stimulus();
      check_output("fair_grant", 32'(last_grant), 32'(k % N));
    end
    req_valid = '0;
    apply_stimulus();

    // Pointer parked at 2 with only 0 and 1 requesting
    req_valid = 4'b0010;
    apply_stimulus();
    req_valid = 4'b0011;
    apply_stimulus();
    check_output("wrap_grant0", 32'(last_grant), 32'h0);
    apply_stimulus();
    check_output("wrap_grant1", 32'(last_grant), 32'h1);
    req_valid = '0;
    apply_stimulus();

    // Enable drop: in-flight product drains, no new grants
    req_valid = 4'b1111;
    apply_stimulus();
    en = 1'b0;
    apply_stimulus();
    #3;
    check_output("en_low_busy", 32'(busy), 32'h0);
    check_output("en_low_ready", 32'(req_ready), 32'h0);
    apply_stimulus();
    en = 1'b1;
    req_valid = '0;
    apply_stimulus();

    // Reset in the cycle after a grant discards the in-flight result
    req_valid = 4'b0001;
    apply_stimulus();
    do_reset();
    apply_stimulus();
    req_valid = 4'b0110;
    apply_stimulus();
    check_output("post_reset_grant", 32'(last_grant), 32'h1);
    req_valid = '0;
    apply_stimulus();

    // Randomized traffic with occasional enable drops and operand changes
    for (int k = 0; k < 300; k++) begin
      req_valid = N'($urandom);
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) set_ops(i, int'($urandom_range(1, 64)), int'($urandom_range(1, 64)));
      apply_stimulus();
    end
    en = 1'b1;
    req_valid = '0;
    apply_stimulus();
    apply_stimulus();

    // Spurious multiplier valid sets a sticky error
    force_mv = 1'b1;
    apply_stimulus();
    force_mv = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check_output("err_sticky", 32'(err), 32'h1);
    do_reset();
    apply_stimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
